breakpoint_unit: RTL and testbench
==================================

Name: breakpoint_unit

Overview:
- Hardware consumer of the statement-trace stream that instrumented RTL emits; each executed statement reports its statement ID.
- Holds a small table of armed breakpoint IDs. On a trace event whose ID matches an armed entry, or on any event in single-step mode, the block halts the design and back-pressures the stream.
- Stays halted until a debugger issues resume.
- Sits between the instrumented design's trace port and the debug host's control/status registers.

Parameters:
- ID_WIDTH, 32, width of statement IDs.
- NUM_BP, 8, number of breakpoint table entries; power of two, minimum 2.
- CNT_WIDTH, 16, width of the saturating halt counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- trace_valid  input  1  trace event present.
- trace_ready  output  1  block accepts the event this cycle.
- trace_id  input  ID_WIDTH  statement ID of the event.
- cfg_we  input  1  breakpoint table write strobe.
- cfg_idx  input  $clog2(NUM_BP)  table entry to write.
- cfg_id  input  ID_WIDTH  ID to store.
- cfg_en  input  1  arm (1) or disarm (0) the entry.
- step_mode  input  1  halt on every accepted event.
- resume  input  1  release from halt; level-sampled.
- halted  output  1  design is stopped at a statement.
- halt_id  output  ID_WIDTH  statement ID that caused the halt.
- halt_hit_idx  output  $clog2(NUM_BP)  matching table entry; 0 when the halt came from step_mode only.
- halt_by_step  output  1  halt caused by step_mode with no table match.
- event_count  output  32  accepted trace events; wraps.
- halt_count  output  CNT_WIDTH  halts taken; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All table entries are disarmed and their IDs cleared.
  - State RUN; halted=0, trace_ready=1 after reset.
  - halt_id=0, halt_hit_idx=0, halt_by_step=0, event_count=0, halt_count=0.
- Reset mid-halt: the block returns to RUN immediately, and the pending halt is discarded.
- State machine, two states:
  - RUN: trace_ready=1, halted=0.
  - HALTED: trace_ready=0, halted=1.
- Handshake: an event is accepted when trace_valid & trace_ready in the same cycle. trace_id must be stable while trace_valid is high and unaccepted.
- Accept in RUN at cycle N:
  - event_count increments at N+1.
  - Match is computed combinationally in cycle N against the table contents registered before N.
  - Match or step_mode=1: at N+1 the state is HALTED; halt_id, halt_hit_idx and halt_by_step are captured and halt_count increments unless saturated.
  - No match: stay in RUN, so back-to-back events are accepted every cycle.
- Match rule: entry i matches when armed and its stored ID equals trace_id. With multiple matches, the lowest index wins. A table match takes precedence over step mode for halt_by_step, so halt_by_step=0 whenever any entry matches.
- HALTED:
  - resume=1 sampled at cycle M gives RUN at M+1, with trace_ready=1 at M+1.
  - The halting event was already consumed, so execution continues with the next event.
  - halt_id, halt_hit_idx and halt_by_step hold their values until the next halt.
- resume in RUN is ignored. If resume is held high, it does not suppress a subsequent halt.
- Table writes:
  - A write with cfg_we at cycle K is visible to matching from K+1.
  - A write in the same cycle as a matching accept does not affect that accept; the old contents are used.
  - Writes are allowed in both states.
- step_mode changes take effect on the next accepted event.
- Counters: event_count wraps from 2^32-1 to 0. halt_count sticks at 2^CNT_WIDTH-1.

Test Plan:
1. Reset with no table writes, then events 0,1,2,3,4,5 on consecutive cycles: all accepted, halted stays 0, event_count=6.
2. Arm entry 3 with ID 0x2, then stream 0,2,3: halt at the cycle after ID 2 is accepted. Required: halt_id=0x2, halt_hit_idx=3, halt_by_step=0, trace_ready=0, and ID 3 held. After a resume pulse, ID 3 is accepted on the next cycle; halt_count=1.
3. Arm entries 5 and 1, both with ID 0x4, then send event 0x4: halt_hit_idx=1.
4. step_mode=1 with an empty table, send 0x0: halt with halt_by_step=1, halt_id=0. Resume, send 0x1: halt again with halt_id=1.
5. Same-cycle case: write entry 0 with ID 0x7 in the cycle event 0x7 is accepted: no halt. Send 0x7 again afterwards: halt.
6. Assert rst_n low while halted: halted=0 and trace_ready=1 immediately, table disarmed. Force halt_count to saturation: the next halt keeps it at 0xFFFF.

Source files
------------

// File: rtl/breakpoint_unit.sv
// ----------------------------------------------------------------------------
// breakpoint_unit
//
// Consumes the statement-trace stream produced by instrumented RTL. A small
// table of armed breakpoint IDs is compared against each accepted trace event.
// On a match, or on any accepted event while single-stepping, the block halts
// the design by dropping trace_ready and stays halted until the debugger
// raises resume.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   trace_valid/ready valid/ready handshake of the trace stream
//   trace_id          statement ID of the current trace event
//   cfg_we/idx/id/en  breakpoint table write port (arm/disarm one entry)
//   step_mode         halt on every accepted event
//   resume            level-sampled release from halt
//   halted            design stopped at a statement
//   halt_id           statement ID that caused the last halt
//   halt_hit_idx      table entry that matched (0 for a pure step halt)
//   halt_by_step      last halt came from step_mode with no table match
//   event_count       accepted events, wrapping
//   halt_count        halts taken, saturating at all-ones
// ----------------------------------------------------------------------------
module breakpoint_unit #(
    parameter  int ID_WIDTH  = 32,
    parameter  int NUM_BP    = 8,
    parameter  int CNT_WIDTH = 16,
    localparam int IDX_WIDTH = $clog2(NUM_BP)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trace_valid,
    output logic                 trace_ready,
    input  logic [ID_WIDTH-1:0]  trace_id,
    input  logic                 cfg_we,
    input  logic [IDX_WIDTH-1:0] cfg_idx,
    input  logic [ID_WIDTH-1:0]  cfg_id,
    input  logic                 cfg_en,
    input  logic                 step_mode,
    input  logic                 resume,
    output logic                 halted,
    output logic [ID_WIDTH-1:0]  halt_id,
    output logic [IDX_WIDTH-1:0] halt_hit_idx,
    output logic                 halt_by_step,
    output logic [31:0]          event_count,
    output logic [CNT_WIDTH-1:0] halt_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t               state;
    logic [ID_WIDTH-1:0]  bp_id [NUM_BP];
    logic [NUM_BP-1:0]    bp_en;
    logic                 match_found;
    logic [IDX_WIDTH-1:0] match_idx;
    logic                 accept;

    // An event is consumed only while running; trace_ready is the registered
    // RUN indication, so this is exactly the valid/ready handshake.
    assign accept = trace_valid && trace_ready;

    // Breakpoint table. A write lands at the clock edge, so an accept in the
    // same cycle still sees the old contents through the comparator below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_en <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_id[i] <= '0;
            end
        end else if (cfg_we) begin
            bp_id[cfg_idx] <= cfg_id;
            bp_en[cfg_idx] <= cfg_en;
        end
    end

    // Parallel compare against every armed entry. Scanning from the top down
    // lets the lowest matching index overwrite any higher one, so the lowest
    // index wins when several entries hold the same ID.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && (bp_id[i] == trace_id)) begin
                match_found = 1'b1;
                match_idx   = IDX_WIDTH'(i);
            end
        end
    end

    // Run/halt state machine with registered handshake and status outputs.
    // The halting event itself is consumed, so after resume the stream
    // continues with the following event. resume is ignored while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            halted       <= 1'b0;
            trace_ready  <= 1'b1;
            halt_id      <= '0;
            halt_hit_idx <= '0;
            halt_by_step <= 1'b0;
            event_count  <= '0;
            halt_count   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        event_count <= event_count + 32'd1;
                        if (match_found || step_mode) begin
                            state        <= HALTED;
                            halted       <= 1'b1;
                            trace_ready  <= 1'b0;
                            halt_id      <= trace_id;
                            halt_hit_idx <= match_found ? match_idx : '0;
                            halt_by_step <= !match_found;
                            if (halt_count != '1) begin
                                halt_count <= halt_count + 1'b1;
                            end
                        end
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state       <= RUN;
                        halted      <= 1'b0;
                        trace_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= RUN;
                    halted      <= 1'b0;
                    trace_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_breakpoint_unit.sv
// ----------------------------------------------------------------------------
// tb_breakpoint_unit
//
// Table-driven bench for breakpoint_unit. Inputs are driven on the falling
// edge, the design samples them on the rising edge, and outputs are compared
// on the following falling edge. A second, small instance (CNT_WIDTH=3) is
// used to reach halt_count saturation in a handful of cycles.
// ----------------------------------------------------------------------------
module tb_breakpoint_unit;

    typedef struct {
        logic        valid;
        logic [31:0] id;
        logic        we;
        logic [2:0]  idx;
        logic [31:0] cid;
        logic        en;
        logic        step;
        logic        resume;
        logic        e_halted;
        logic [31:0] e_hid;
        logic [2:0]  e_idx;
        logic        e_bs;
        logic [31:0] e_ec;
        logic [15:0] e_hc;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_id;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [31:0] cfg_id;
    logic        cfg_en;
    logic        step_mode;
    logic        resume;
    logic        halted;
    logic [31:0] halt_id;
    logic [2:0]  halt_hit_idx;
    logic        halt_by_step;
    logic [31:0] event_count;
    logic [15:0] halt_count;

    logic        s_rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_id;
    logic        s_step;
    logic        s_resume;
    logic        s_halted;
    logic [7:0]  s_halt_id;
    logic        s_hit_idx;
    logic        s_by_step;
    logic [31:0] s_event_count;
    logic [2:0]  s_halt_count;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    breakpoint_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_id     (trace_id),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_id       (cfg_id),
        .cfg_en       (cfg_en),
        .step_mode    (step_mode),
        .resume       (resume),
        .halted       (halted),
        .halt_id      (halt_id),
        .halt_hit_idx (halt_hit_idx),
        .halt_by_step (halt_by_step),
        .event_count  (event_count),
        .halt_count   (halt_count)
    );

    breakpoint_unit #(
        .ID_WIDTH  (8),
        .NUM_BP    (2),
        .CNT_WIDTH (3)
    ) dut_sat (
        .clk          (clk),
        .rst_n        (s_rst_n),
        .trace_valid  (s_valid),
        .trace_ready  (s_ready),
        .trace_id     (s_id),
        .cfg_we       (1'b0),
        .cfg_idx      (1'b0),
        .cfg_id       (8'h00),
        .cfg_en       (1'b0),
        .step_mode    (s_step),
        .resume       (s_resume),
        .halted       (s_halted),
        .halt_id      (s_halt_id),
        .halt_hit_idx (s_hit_idx),
        .halt_by_step (s_by_step),
        .event_count  (s_event_count),
        .halt_count   (s_halt_count)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic valid, input logic [31:0] id,
        input logic we, input logic [2:0] idx, input logic [31:0] cid, input logic en,
        input logic step, input logic rsm,
        input logic e_halted, input logic [31:0] e_hid, input logic [2:0] e_idx,
        input logic e_bs, input logic [31:0] e_ec, input logic [15:0] e_hc);
        vec_t v;
        v.valid = valid; v.id = id; v.we = we; v.idx = idx; v.cid = cid; v.en = en;
        v.step = step; v.resume = rsm;
        v.e_halted = e_halted; v.e_hid = e_hid; v.e_idx = e_idx;
        v.e_bs = e_bs; v.e_ec = e_ec; v.e_hc = e_hc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        trace_valid = v.valid;
        trace_id    = v.id;
        cfg_we      = v.we;
        cfg_idx     = v.idx;
        cfg_id      = v.cid;
        cfg_en      = v.en;
        step_mode   = v.step;
        resume      = v.resume;
    endtask

    task automatic checkAll(input string tag, input logic e_halted, input logic [31:0] e_hid,
                            input logic [2:0] e_idx, input logic e_bs,
                            input logic [31:0] e_ec, input logic [15:0] e_hc);
        checkOutput({tag, ".halted"},       32'(halted),       32'(e_halted));
        checkOutput({tag, ".trace_ready"},  32'(trace_ready),  32'(!e_halted));
        checkOutput({tag, ".halt_id"},      halt_id,           e_hid);
        checkOutput({tag, ".halt_hit_idx"}, 32'(halt_hit_idx), 32'(e_idx));
        checkOutput({tag, ".halt_by_step"}, 32'(halt_by_step), 32'(e_bs));
        checkOutput({tag, ".event_count"},  event_count,       e_ec);
        checkOutput({tag, ".halt_count"},   32'(halt_count),   32'(e_hc));
    endtask

    initial begin
        rst_n       = 1'b0;
        s_rst_n     = 1'b0;
        trace_valid = 1'b0;
        trace_id    = '0;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_id      = '0;
        cfg_en      = 1'b0;
        step_mode   = 1'b0;
        resume      = 1'b0;
        s_valid     = 1'b0;
        s_id        = 8'h03;
        s_step      = 1'b0;
        s_resume    = 1'b0;

        // Stream 0..5 into an empty table
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1, i, 0,0,0,0, 0,0, 0, 0,0,0, 32'(i + 1), 0));
        // Arm entry 3 with ID 2, halt on 2, hold 3 until resume
        vecs.push_back(mk(0, 0, 1,3,2,1, 0,0, 0, 0,0,0, 6, 0));
        vecs.push_back(mk(1, 0, 0,0,0,0, 0,0, 0, 0,0,0, 7, 0));
        vecs.push_back(mk(1, 2, 0,0,0,0, 0,0, 1, 2,3,0, 8, 1));
        vecs.push_back(mk(1, 3, 0,0,0,0, 0,0, 1, 2,3,0, 8, 1));
        vecs.push_back(mk(1, 3, 0,0,0,0, 0,1, 0, 2,3,0, 8, 1));
        vecs.push_back(mk(1, 3, 0,0,0,0, 0,0, 0, 2,3,0, 9, 1));
        // Entries 5 and 1 both hold ID 4: lowest index wins
        vecs.push_back(mk(0, 0, 1,5,4,1, 0,0, 0, 2,3,0, 9, 1));
        vecs.push_back(mk(0, 0, 1,1,4,1, 0,0, 0, 2,3,0, 9, 1));
        vecs.push_back(mk(1, 4, 0,0,0,0, 0,0, 1, 4,1,0, 10, 2));
        vecs.push_back(mk(0, 0, 0,0,0,0, 0,1, 0, 4,1,0, 10, 2));
        // resume held high while running does not suppress the next halt
        vecs.push_back(mk(1, 4, 0,0,0,0, 0,1, 1, 4,1,0, 11, 3));
        vecs.push_back(mk(0, 0, 0,0,0,0, 0,1, 0, 4,1,0, 11, 3));
        // Disarm 1,3,5 then single-step
        vecs.push_back(mk(0, 0, 1,1,0,0, 0,0, 0, 4,1,0, 11, 3));
        vecs.push_back(mk(0, 0, 1,3,0,0, 0,0, 0, 4,1,0, 11, 3));
        vecs.push_back(mk(0, 0, 1,5,0,0, 0,0, 0, 4,1,0, 11, 3));
        vecs.push_back(mk(1, 0, 0,0,0,0, 1,0, 1, 0,0,1, 12, 4));
        vecs.push_back(mk(0, 0, 0,0,0,0, 1,1, 0, 0,0,1, 12, 4));
        vecs.push_back(mk(1, 1, 0,0,0,0, 1,0, 1, 1,0,1, 13, 5));
        vecs.push_back(mk(0, 0, 0,0,0,0, 1,1, 0, 1,0,1, 13, 5));
        // Step mode plus a table match: halt_by_step must be 0
        vecs.push_back(mk(0, 0, 1,2,9,1, 1,0, 0, 1,0,1, 13, 5));
        vecs.push_back(mk(1, 9, 0,0,0,0, 1,0, 1, 9,2,0, 14, 6));
        vecs.push_back(mk(0, 0, 0,0,0,0, 0,1, 0, 9,2,0, 14, 6));
        vecs.push_back(mk(0, 0, 1,2,0,0, 0,0, 0, 9,2,0, 14, 6));
        // Write in the same cycle as the matching accept uses old contents
        vecs.push_back(mk(1, 7, 1,0,7,1, 0,0, 0, 9,2,0, 15, 6));
        vecs.push_back(mk(1, 7, 0,0,0,0, 0,0, 1, 7,0,0, 16, 7));
        // Disarm while halted, then the same ID streams through
        vecs.push_back(mk(0, 0, 1,0,7,0, 0,0, 1, 7,0,0, 16, 7));
        vecs.push_back(mk(0, 0, 0,0,0,0, 0,1, 0, 7,0,0, 16, 7));
        vecs.push_back(mk(1, 7, 0,0,0,0, 0,0, 0, 7,0,0, 17, 7));
        vecs.push_back(mk(1, 0, 0,0,0,0, 0,0, 0, 7,0,0, 18, 7));

        // Reset state
        repeat (2) @(negedge clk);
        checkAll("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkAll($sformatf("vec%0d", i), vecs[i].e_halted, vecs[i].e_hid,
                     vecs[i].e_idx, vecs[i].e_bs, vecs[i].e_ec, vecs[i].e_hc);
        end

        // Halt on entry 6, then reset asynchronously mid-halt
        applyStimulus(mk(0, 0, 1,6,32'hA,1, 0,0, 0,0,0,0,0,0));
        @(negedge clk);
        applyStimulus(mk(1, 32'hA, 0,0,0,0, 0,0, 0,0,0,0,0,0));
        @(negedge clk);
        checkAll("halt6", 1, 32'hA, 6, 0, 19, 8);
        trace_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkAll("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mk(1, 32'hA, 0,0,0,0, 0,0, 0,0,0,0,0,0));
        @(negedge clk);
        checkAll("after_reset", 0, 0, 0, 0, 1, 0);
        applyStimulus(mk(1, 32'h4, 0,0,0,0, 0,0, 0,0,0,0,0,0));
        @(negedge clk);
        checkAll("after_reset2", 0, 0, 0, 0, 2, 0);
        trace_valid = 1'b0;

        // Saturation on the narrow instance: step mode with resume held
        // high halts on every other rising edge.
        s_rst_n  = 1'b1;
        s_valid  = 1'b1;
        s_step   = 1'b1;
        s_resume = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            int exp_halts;
            @(negedge clk);
            exp_halts = (e + 1) / 2;
            if (exp_halts > 7) exp_halts = 7;
            checkOutput($sformatf("sat.halt_count.e%0d", e), 32'(s_halt_count), 32'(exp_halts));
            checkOutput($sformatf("sat.halted.e%0d", e), 32'(s_halted), 32'(e % 2));
        end
        checkOutput("sat.event_count", s_event_count, 32'd10);
        checkOutput("sat.halt_by_step", 32'(s_by_step), 32'd1);
        checkOutput("sat.halt_id", 32'(s_halt_id), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
